// File: rtl/usb_rx_packet_pkg.sv
// Shared PID codes, CRC constants and FSM encoding for the UTMI receive packet decoder.
package usb_rx_pkg;

  localparam int DLEN_W = 11;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  localparam logic [4:0]  CRC5_POLY      = 5'h05;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_TOK1,
    ST_TOK2,
    ST_DATA,
    ST_HSK,
    ST_DRAIN
  } rx_state_t;

  typedef enum logic [1:0] {
    PK_TOKEN,
    PK_DATA,
    PK_HSK
  } pid_class_t;

  // Reserved/special PIDs share the handshake path: no payload is expected after them.
  function automatic pid_class_t pid_class(input logic [3:0] pid);
    pid_class_t c;
    c = PK_HSK;
    case (pid)
      PID_OUT, PID_IN, PID_SOF, PID_SETUP: c = PK_TOKEN;
      PID_DATA0, PID_DATA1:                c = PK_DATA;
      PID_ACK, PID_NAK, PID_STALL:         c = PK_HSK;
      default:                             c = PK_HSK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/usb_rx_packet_if.sv
// UTMI receive-side signals from the PHY; the PHY (or a bench) drives master, the decoder takes slave.
interface usb_rx_packet_if;
  logic [7:0] utmi_data_in_i;
  logic       utmi_rxvalid_i;
  logic       utmi_rxactive_i;
  logic       utmi_rxerror_i;

  modport master (
    output utmi_data_in_i, utmi_rxvalid_i, utmi_rxactive_i, utmi_rxerror_i
  );

  modport slave (
    input utmi_data_in_i, utmi_rxvalid_i, utmi_rxactive_i, utmi_rxerror_i
  );
endinterface

// File: rtl/usb_rx_packet_crc_byte.sv
// Combinational next-CRC over one byte, LSB first; W/POLY select CRC5 or CRC16.
module usb_crc_byte #(
  parameter int         W    = 5,
  parameter logic [W-1:0] POLY = '0
) (
  input  logic [W-1:0] crc_i,
  input  logic [7:0]   data_i,
  output logic [W-1:0] crc_o
);

  always_comb begin
    logic [W-1:0] c;
    c = crc_i;
    for (int i = 0; i < 8; i++) begin
      if (data_i[i] ^ c[W-1]) c = {c[W-2:0], 1'b0} ^ POLY;
      else                    c = {c[W-2:0], 1'b0};
    end
    crc_o = c;
  end

endmodule

// File: rtl/usb_rx_packet.sv
// Decodes UTMI RX bytes into PID/token/payload with CRC checks; pkt_done one clock after rxactive falls.
// No backpressure: every rxvalid byte is consumed in the clock it arrives.
module usb_rx_packet
  import usb_rx_pkg::*;
#(
  parameter int MAX_DATA = 1023
) (
  input  logic              clk_i,
  input  logic              rst_i,
  usb_rx_packet_if.slave    utmi,
  output logic              pkt_start_o,
  output logic [3:0]        pid_o,
  output logic              token_valid_o,
  output logic [6:0]        token_addr_o,
  output logic [3:0]        token_endp_o,
  output logic [10:0]       frame_num_o,
  output logic [7:0]        data_o,
  output logic              data_valid_o,
  output logic [DLEN_W-1:0] data_len_o,
  output logic              pkt_done_o,
  output logic              pkt_ok_o,
  output logic              pid_err_o,
  output logic              crc_err_o,
  output logic              len_err_o,
  output logic              rx_err_o
);

  localparam logic [DLEN_W-1:0] MAX_LEN = DLEN_W'(MAX_DATA);

  rx_state_t         state_q, state_d;
  logic              act_q;
  logic [7:0]        tok_b1_q, tok_b1_d;
  logic [2:0]        tok_b2_q, tok_b2_d;
  logic [7:0]        h0_q, h0_d, h1_q, h1_d;
  logic [1:0]        hcnt_q, hcnt_d;
  logic              tok_drain_q, tok_drain_d;
  logic [4:0]        crc5_q, crc5_d, crc5_nxt;
  logic [15:0]       crc16_q, crc16_d, crc16_nxt;
  logic [3:0]        pid_d;
  logic [DLEN_W-1:0] len_d;
  logic [7:0]        data_d;
  logic              start_d, tokv_d, dv_d, done_d, ok_d;
  logic              pid_err_d, crc_err_d, len_err_d, rx_err_d;
  logic              end_evt;

  logic [7:0] rx_byte;
  logic       rx_vld;
  logic       rx_act;
  assign rx_byte = utmi.utmi_data_in_i;
  assign rx_vld  = utmi.utmi_rxvalid_i;
  assign rx_act  = utmi.utmi_rxactive_i;

  assign token_addr_o = tok_b1_q[6:0];
  assign token_endp_o = {tok_b2_q, tok_b1_q[7]};
  assign frame_num_o  = {tok_b2_q, tok_b1_q};

  usb_crc_byte #(.W(5), .POLY(CRC5_POLY)) u_crc5 (
    .crc_i  (crc5_q),
    .data_i (rx_byte),
    .crc_o  (crc5_nxt)
  );

  usb_crc_byte #(.W(16), .POLY(CRC16_POLY)) u_crc16 (
    .crc_i  (crc16_q),
    .data_i (rx_byte),
    .crc_o  (crc16_nxt)
  );

  always_comb begin
    state_d     = state_q;
    tok_b1_d    = tok_b1_q;
    tok_b2_d    = tok_b2_q;
    h0_d        = h0_q;
    h1_d        = h1_q;
    hcnt_d      = hcnt_q;
    tok_drain_d = tok_drain_q;
    crc5_d      = crc5_q;
    crc16_d     = crc16_q;
    pid_d       = pid_o;
    len_d       = data_len_o;
    data_d      = data_o;
    pid_err_d   = pid_err_o;
    crc_err_d   = crc_err_o;
    len_err_d   = len_err_o;
    rx_err_d    = rx_err_o;
    start_d     = 1'b0;
    tokv_d      = 1'b0;
    dv_d        = 1'b0;
    done_d      = 1'b0;
    ok_d        = 1'b0;
    end_evt     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_act && !act_q) state_d = ST_PID;
      end

      ST_PID: begin
        if (rx_vld) begin
          pid_d       = rx_byte[3:0];
          start_d     = 1'b1;
          pid_err_d   = 1'b0;
          crc_err_d   = 1'b0;
          len_err_d   = 1'b0;
          rx_err_d    = 1'b0;
          len_d       = '0;
          hcnt_d      = '0;
          tok_drain_d = 1'b0;
          crc5_d      = '1;
          crc16_d     = '1;
          if (rx_byte[7:4] != ~rx_byte[3:0]) begin
            pid_err_d = 1'b1;
            state_d   = ST_DRAIN;
          end else begin
            unique case (pid_class(rx_byte[3:0]))
              PK_TOKEN: state_d = ST_TOK1;
              PK_DATA:  state_d = ST_DATA;
              default:  state_d = ST_HSK;
            endcase
          end
        end else if (!rx_act) begin
          end_evt = 1'b1;
        end
      end

      ST_TOK1: begin
        if (rx_vld) begin
          tok_b1_d = rx_byte;
          crc5_d   = crc5_nxt;
          state_d  = ST_TOK2;
        end else if (!rx_act) begin
          len_err_d = 1'b1;
          end_evt   = 1'b1;
        end
      end

      // The token is reported even with a bad CRC; pkt_ok qualifies it at packet end.
      ST_TOK2: begin
        if (rx_vld) begin
          tok_b2_d    = rx_byte[2:0];
          crc5_d      = crc5_nxt;
          tokv_d      = 1'b1;
          tok_drain_d = 1'b1;
          state_d     = ST_DRAIN;
          if (crc5_nxt != CRC5_RESIDUAL) crc_err_d = 1'b1;
        end else if (!rx_act) begin
          len_err_d = 1'b1;
          end_evt   = 1'b1;
        end
      end

      // Two bytes are always held back so the trailing CRC16 never reaches data_o.
      ST_DATA: begin
        if (rx_vld) begin
          crc16_d = crc16_nxt;
          h0_d    = rx_byte;
          h1_d    = h0_q;
          if (hcnt_q == 2'd2) begin
            if (data_len_o == MAX_LEN) begin
              len_err_d = 1'b1;
            end else begin
              dv_d   = 1'b1;
              data_d = h1_q;
              len_d  = data_len_o + 1'b1;
            end
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end else if (!rx_act) begin
          if (hcnt_q != 2'd2)            len_err_d = 1'b1;
          if (crc16_q != CRC16_RESIDUAL) crc_err_d = 1'b1;
          end_evt = 1'b1;
        end
      end

      ST_HSK: begin
        if (rx_vld)       len_err_d = 1'b1;
        else if (!rx_act) end_evt   = 1'b1;
      end

      ST_DRAIN: begin
        if (rx_vld) begin
          if (tok_drain_q) len_err_d = 1'b1;
        end else if (!rx_act) begin
          end_evt = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && utmi.utmi_rxerror_i) rx_err_d = 1'b1;

    if (end_evt) begin
      done_d  = 1'b1;
      ok_d    = !(pid_err_d || crc_err_d || len_err_d || rx_err_d);
      state_d = ST_IDLE;
    end
  end

  // act_q resets high so a packet already in flight at reset release is not picked up mid-stream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      act_q         <= 1'b1;
      tok_b1_q      <= '0;
      tok_b2_q      <= '0;
      h0_q          <= '0;
      h1_q          <= '0;
      hcnt_q        <= '0;
      tok_drain_q   <= 1'b0;
      crc5_q        <= '1;
      crc16_q       <= '1;
      pkt_start_o   <= 1'b0;
      pid_o         <= '0;
      token_valid_o <= 1'b0;
      data_o        <= '0;
      data_valid_o  <= 1'b0;
      data_len_o    <= '0;
      pkt_done_o    <= 1'b0;
      pkt_ok_o      <= 1'b0;
      pid_err_o     <= 1'b0;
      crc_err_o     <= 1'b0;
      len_err_o     <= 1'b0;
      rx_err_o      <= 1'b0;
    end else begin
      state_q       <= state_d;
      act_q         <= rx_act;
      tok_b1_q      <= tok_b1_d;
      tok_b2_q      <= tok_b2_d;
      h0_q          <= h0_d;
      h1_q          <= h1_d;
      hcnt_q        <= hcnt_d;
      tok_drain_q   <= tok_drain_d;
      crc5_q        <= crc5_d;
      crc16_q       <= crc16_d;
      pkt_start_o   <= start_d;
      pid_o         <= pid_d;
      token_valid_o <= tokv_d;
      data_o        <= data_d;
      data_valid_o  <= dv_d;
      data_len_o    <= len_d;
      pkt_done_o    <= done_d;
      pkt_ok_o      <= ok_d;
      pid_err_o     <= pid_err_d;
      crc_err_o     <= crc_err_d;
      len_err_o     <= len_err_d;
      rx_err_o      <= rx_err_d;
    end
  end

endmodule

// File: tb/tb_usb_rx_packet.sv
// Directed bench for usb_rx_packet: tokens, data, handshakes, error flags and reset behaviour.
module tb_usb_rx_packet;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  usb_rx_packet_if utmi();

  logic        pkt_start_o, token_valid_o, data_valid_o, pkt_done_o, pkt_ok_o;
  logic [3:0]  pid_o, token_endp_o;
  logic [6:0]  token_addr_o;
  logic [10:0] frame_num_o, data_len_o;
  logic [7:0]  data_o;
  logic        pid_err_o, crc_err_o, len_err_o, rx_err_o;

  logic        m_pkt_start, m_token_valid, m_data_valid, m_pkt_done, m_pkt_ok;
  logic [3:0]  m_pid, m_token_endp;
  logic [6:0]  m_token_addr;
  logic [10:0] m_frame_num, m_data_len;
  logic [7:0]  m_data;
  logic        m_pid_err, m_crc_err, m_len_err, m_rx_err;

  usb_rx_packet #(.MAX_DATA(1023)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .utmi(utmi),
    .pkt_start_o(pkt_start_o), .pid_o(pid_o), .token_valid_o(token_valid_o),
    .token_addr_o(token_addr_o), .token_endp_o(token_endp_o), .frame_num_o(frame_num_o),
    .data_o(data_o), .data_valid_o(data_valid_o), .data_len_o(data_len_o),
    .pkt_done_o(pkt_done_o), .pkt_ok_o(pkt_ok_o),
    .pid_err_o(pid_err_o), .crc_err_o(crc_err_o), .len_err_o(len_err_o), .rx_err_o(rx_err_o)
  );

  usb_rx_packet #(.MAX_DATA(4)) u_dut_max4 (
    .clk_i(clk_i), .rst_i(rst_i), .utmi(utmi),
    .pkt_start_o(m_pkt_start), .pid_o(m_pid), .token_valid_o(m_token_valid),
    .token_addr_o(m_token_addr), .token_endp_o(m_token_endp), .frame_num_o(m_frame_num),
    .data_o(m_data), .data_valid_o(m_data_valid), .data_len_o(m_data_len),
    .pkt_done_o(m_pkt_done), .pkt_ok_o(m_pkt_ok),
    .pid_err_o(m_pid_err), .crc_err_o(m_crc_err), .len_err_o(m_len_err), .rx_err_o(m_rx_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int n_start, n_tokv, n_done, n_dv, m_n_dv, m_n_done;
  logic ok_s, m_ok_s, done_now;
  logic [7:0] dq[$];
  logic [7:0] pkt[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (pkt_start_o)   n_start++;
    if (token_valid_o) n_tokv++;
    if (data_valid_o)  begin n_dv++; dq.push_back(data_o); end
    if (pkt_done_o)    begin n_done++; ok_s = pkt_ok_o; end
    if (m_data_valid)  m_n_dv++;
    if (m_pkt_done)    begin m_n_done++; m_ok_s = m_pkt_ok; end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr();
    n_start = 0; n_tokv = 0; n_done = 0; n_dv = 0; m_n_dv = 0; m_n_done = 0;
    ok_s = 1'b0; m_ok_s = 1'b0;
    dq.delete();
  endtask

  // Drives pkt[] back to back; err_at marks the byte carrying rxerror, fall_last drops rxactive with the last byte.
  task automatic send(input int err_at, input bit fall_last);
    clr();
    utmi.utmi_rxactive_i = 1'b1;
    tick();
    for (int i = 0; i < pkt.size(); i++) begin
      utmi.utmi_data_in_i = pkt[i];
      utmi.utmi_rxvalid_i = 1'b1;
      utmi.utmi_rxerror_i = (i == err_at);
      if (fall_last && i == pkt.size() - 1) utmi.utmi_rxactive_i = 1'b0;
      tick();
    end
    utmi.utmi_rxvalid_i  = 1'b0;
    utmi.utmi_rxerror_i  = 1'b0;
    utmi.utmi_rxactive_i = 1'b0;
    tick();
    done_now = pkt_done_o;
    repeat (4) tick();
  endtask

  function automatic logic [4:0] crc5_field(input logic [10:0] f);
    logic [4:0] c;
    logic [4:0] r;
    c = 5'h1F;
    for (int i = 0; i < 11; i++)
      c = (c[4] ^ f[i]) ? ({c[3:0], 1'b0} ^ 5'h05) : {c[3:0], 1'b0};
    for (int j = 0; j < 5; j++) r[j] = ~c[4-j];
    return r;
  endfunction

  task automatic append_crc16();
    logic [15:0] c;
    logic [15:0] r;
    c = 16'hFFFF;
    for (int i = 1; i < pkt.size(); i++)
      for (int b = 0; b < 8; b++)
        c = (c[15] ^ pkt[i][b]) ? ({c[14:0], 1'b0} ^ 16'h8005) : {c[14:0], 1'b0};
    for (int i = 0; i < 16; i++) r[i] = ~c[15-i];
    pkt.push_back(r[7:0]);
    pkt.push_back(r[15:8]);
  endtask

  task automatic chk_payload(input string tag, input int n);
    chk({tag, "_cnt"}, 32'(n_dv), 32'(n));
    for (int i = 0; i < n; i++)
      chk({tag, "_byte"}, (i < dq.size()) ? 32'(dq[i]) : 32'hFFFF_FFFF, 32'(pkt[i+1]));
  endtask

  initial begin
    rst_i = 1'b1;
    utmi.utmi_data_in_i  = '0;
    utmi.utmi_rxvalid_i  = 1'b0;
    utmi.utmi_rxactive_i = 1'b0;
    utmi.utmi_rxerror_i  = 1'b0;
    clr();
    repeat (3) tick();
    chk("rst_pid", 32'(pid_o), 32'h0);
    chk("rst_len", 32'(data_len_o), 32'h0);
    chk("rst_pulses", 32'({pkt_start_o, token_valid_o, data_valid_o, pkt_done_o, pkt_ok_o}), 32'h0);
    chk("rst_flags", 32'({pid_err_o, crc_err_o, len_err_o, rx_err_o}), 32'h0);
    rst_i = 1'b0;
    repeat (2) tick();

    // SETUP addr 0 endp 0
    pkt = '{8'h2D, 8'h00, 8'h10};
    send(-1, 1'b0);
    chk("setup_pid", 32'(pid_o), 32'hD);
    chk("setup_start", 32'(n_start), 32'd1);
    chk("setup_tokv", 32'(n_tokv), 32'd1);
    chk("setup_addr_endp", 32'({token_addr_o, token_endp_o}), 32'h0);
    chk("setup_done", 32'(n_done), 32'd1);
    chk("setup_ok", 32'(ok_s), 32'd1);
    chk("done_latency", 32'(done_now), 32'd1);

    // same token, corrupted CRC byte
    pkt = '{8'h2D, 8'h00, 8'h11};
    send(-1, 1'b0);
    chk("badcrc_flag", 32'(crc_err_o), 32'd1);
    chk("badcrc_ok", 32'(ok_s), 32'd0);
    chk("badcrc_tokv", 32'(n_tokv), 32'd1);

    // IN token addr 0x15 endp 0xB, rxactive falling with the last byte
    pkt = '{8'h69, 8'h95, 8'h00};
    pkt[2] = {crc5_field(11'h595), 3'b101};
    send(-1, 1'b1);
    chk("in_addr", 32'(token_addr_o), 32'h15);
    chk("in_endp", 32'(token_endp_o), 32'hB);
    chk("in_fall_done", 32'(n_done), 32'd1);
    chk("in_fall_ok", 32'(ok_s), 32'd1);

    // SOF frame 0x53A
    pkt = '{8'hA5, 8'h3A, 8'h00};
    pkt[2] = {crc5_field(11'h53A), 3'b101};
    send(-1, 1'b0);
    chk("sof_frame", 32'(frame_num_o), 32'h53A);
    chk("sof_ok", 32'(ok_s), 32'd1);

    // zero-length DATA0
    pkt = '{8'hC3, 8'h00, 8'h00};
    send(-1, 1'b0);
    chk("zlp_dv", 32'(n_dv), 32'd0);
    chk("zlp_len", 32'(data_len_o), 32'd0);
    chk("zlp_ok", 32'(ok_s), 32'd1);

    // DATA1, 8 payload bytes
    pkt = '{8'h4B, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    append_crc16();
    send(-1, 1'b0);
    chk("d8_pid", 32'(pid_o), 32'hB);
    chk_payload("d8", 8);
    chk("d8_len", 32'(data_len_o), 32'd8);
    chk("d8_ok", 32'(ok_s), 32'd1);

    // 6 payload bytes: full forward on the wide instance, capped at 4 on the narrow one
    pkt = '{8'hC3, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    append_crc16();
    send(-1, 1'b0);
    chk_payload("d6", 6);
    chk("d6_ok", 32'(ok_s), 32'd1);
    chk("max4_dv", 32'(m_n_dv), 32'd4);
    chk("max4_len", 32'(m_data_len), 32'd4);
    chk("max4_flags", 32'({m_crc_err, m_len_err}), 32'b01);
    chk("max4_ok", 32'(m_ok_s), 32'd0);

    // exactly MAX_DATA bytes is still legal
    pkt = '{8'h4B, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    append_crc16();
    send(-1, 1'b0);
    chk("max4_exact_dv", 32'(m_n_dv), 32'd4);
    chk("max4_exact_ok", 32'({m_pkt_done, m_len_err, m_ok_s}), 32'b001);

    // ACK
    pkt = '{8'hD2};
    send(-1, 1'b0);
    chk("ack_pid", 32'(pid_o), 32'h2);
    chk("ack_ok", 32'(ok_s), 32'd1);

    // bad PID complement; trailing bytes ignored
    pkt = '{8'h2E, 8'h00, 8'h10};
    send(-1, 1'b0);
    chk("piderr_flags", 32'({pid_err_o, crc_err_o, len_err_o}), 32'b100);
    chk("piderr_tokv", 32'(n_tokv), 32'd0);
    chk("piderr_ok", 32'({n_done[1:0], ok_s}), 32'b010);

    // DATA0 with only one byte after the PID
    pkt = '{8'hC3, 8'h55};
    send(-1, 1'b0);
    chk("short_data_len_err", 32'(len_err_o), 32'd1);
    chk("short_data_dv", 32'(n_dv), 32'd0);

    // short token, extra token byte, extra handshake byte
    pkt = '{8'h2D, 8'h00};
    send(-1, 1'b0);
    chk("short_tok", 32'({n_tokv[0], len_err_o, ok_s}), 32'b010);
    pkt = '{8'h2D, 8'h00, 8'h10, 8'hFF};
    send(-1, 1'b0);
    chk("long_tok", 32'({crc_err_o, len_err_o, ok_s}), 32'b010);
    pkt = '{8'hD2, 8'h00};
    send(-1, 1'b0);
    chk("long_hsk", 32'({len_err_o, ok_s}), 32'b10);

    // PHY error in the middle of an otherwise good zero-length DATA0
    pkt = '{8'hC3, 8'h00, 8'h00};
    send(1, 1'b0);
    chk("rxerr_flags", 32'({rx_err_o, crc_err_o, len_err_o}), 32'b100);
    chk("rxerr_ok", 32'({n_done[1:0], ok_s}), 32'b010);

    // reset in the middle of a DATA packet
    clr();
    utmi.utmi_rxactive_i = 1'b1;
    tick();
    pkt = '{8'hC3, 8'h01, 8'h02, 8'h03};
    for (int i = 0; i < pkt.size(); i++) begin
      utmi.utmi_data_in_i = pkt[i];
      utmi.utmi_rxvalid_i = 1'b1;
      tick();
    end
    utmi.utmi_rxvalid_i = 1'b0;
    chk("midrst_pre_len", 32'(data_len_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("midrst_pid", 32'(pid_o), 32'h0);
    chk("midrst_len", 32'(data_len_o), 32'h0);
    chk("midrst_data", 32'(data_o), 32'h0);
    utmi.utmi_rxactive_i = 1'b0;
    repeat (2) tick();
    rst_i = 1'b0;
    repeat (5) tick();
    chk("midrst_no_done", 32'(n_done), 32'd0);

    pkt = '{8'h5A};
    send(-1, 1'b0);
    chk("post_rst_nak", 32'({pid_o, ok_s}), 32'({4'hA, 1'b1}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
